// File: rtl/clock_disp_pkg.sv
// Shared definitions for the clock display bus: select codes, blank pattern,
// digit index type, sequence FSM states and the select decoder.
package clock_disp_pkg;

    localparam logic [3:0] SEL_D0    = 4'b1110;
    localparam logic [3:0] SEL_D1    = 4'b1101;
    localparam logic [3:0] SEL_D2    = 4'b1011;
    localparam logic [3:0] SEL_D3    = 4'b0111;
    localparam logic [3:0] SEL_BLANK = 4'b1111;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } seq_state_t;

    typedef enum logic [1:0] {
        SEL_IS_DIGIT   = 2'd0,
        SEL_IS_BLANK   = 2'd1,
        SEL_IS_ILLEGAL = 2'd2
    } sel_kind_t;

    typedef struct packed {
        sel_kind_t  kind;
        digit_idx_t idx;
    } sel_dec_t;

    // Anything that is neither a one-hot-low digit code nor all-ones is illegal.
    function automatic sel_dec_t decode_sel(input logic [3:0] sel);
        sel_dec_t d;
        d.kind = SEL_IS_ILLEGAL;
        d.idx  = 2'd0;
        case (sel)
            SEL_D0: begin
                d.kind = SEL_IS_DIGIT;
                d.idx  = 2'd0;
            end
            SEL_D1: begin
                d.kind = SEL_IS_DIGIT;
                d.idx  = 2'd1;
            end
            SEL_D2: begin
                d.kind = SEL_IS_DIGIT;
                d.idx  = 2'd2;
            end
            SEL_D3: begin
                d.kind = SEL_IS_DIGIT;
                d.idx  = 2'd3;
            end
            SEL_BLANK: d.kind = SEL_IS_BLANK;
            default:   d.kind = SEL_IS_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Multiplexed seven-segment bus plus the demultiplexed capture results.
interface seg_scan_capture_if;

    logic [3:0] Choose;
    logic [6:0] HEX;

    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [3:0] Valid;
    logic       FrameDone;
    logic       SeqErr;
    logic       Timeout;
    logic [7:0] ErrCnt;

    modport master (
        output Choose, HEX,
        input  HEX0, HEX1, HEX2, HEX3, Valid, FrameDone, SeqErr, Timeout, ErrCnt
    );

    modport slave (
        input  Choose, HEX,
        output HEX0, HEX1, HEX2, HEX3, Valid, FrameDone, SeqErr, Timeout, ErrCnt
    );

endinterface

// File: rtl/sync_ff.sv
// Parameterised two-flop synchroniser with a configurable reset value.
module sync_ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Receiving end of the multiplexed 4-digit seven-segment bus: glitch filter,
// demultiplexer, scan-order checker and stalled-scanner detector.
module seg_scan_capture
    import clock_disp_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                CP50,
    input  logic                nCR,
    seg_scan_capture_if.slave   bus
);

    localparam logic [3:0]  STABLE_MAX = 4'(STABLE_CYC);
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT_CYC - 1);
    localparam logic [10:0] SYNC_RST   = {SEL_BLANK, SEG_BLANK};

    logic [10:0] sync_q;
    logic [10:0] s3;
    logic [3:0]  stab_cnt;
    logic [3:0]  stab_next;
    logic        cap_q;
    logic [3:0]  cap_sel;
    logic [6:0]  cap_hex;

    sel_dec_t    dec;
    logic        digit_hit;
    logic        illegal_hit;
    logic        order_err;
    logic        frame_end;
    logic        expire;

    seq_state_t  state;
    digit_idx_t  exp;
    logic        frame_done;
    logic        seq_err;
    logic [7:0]  err_cnt;

    logic [6:0]  hex_q [4];
    logic [3:0]  valid;
    logic [15:0] idle_cnt;
    logic        timeout;

    sync_ff #(
        .WIDTH   (11),
        .RST_VAL (SYNC_RST)
    ) u_sync (
        .clk   (CP50),
        .rst_n (nCR),
        .d     ({bus.Choose, bus.HEX}),
        .q     (sync_q)
    );

    always_comb begin
        if (sync_q == s3) begin
            stab_next = (stab_cnt == STABLE_MAX) ? stab_cnt : stab_cnt + 4'd1;
        end else begin
            stab_next = 4'd1;
        end
    end

    // The capture strobe is registered so it fires once per dwell, on the
    // cycle the stability counter first reaches its ceiling.
    always_ff @(posedge CP50 or negedge nCR) begin
        if (!nCR) begin
            s3       <= SYNC_RST;
            stab_cnt <= 4'd0;
            cap_q    <= 1'b0;
            cap_sel  <= SEL_BLANK;
            cap_hex  <= SEG_BLANK;
        end else begin
            s3       <= sync_q;
            stab_cnt <= stab_next;
            cap_q    <= (stab_next == STABLE_MAX) && (stab_cnt != STABLE_MAX);
            cap_sel  <= sync_q[10:7];
            cap_hex  <= sync_q[6:0];
        end
    end

    always_comb begin
        dec         = decode_sel(cap_sel);
        digit_hit   = cap_q && (dec.kind == SEL_IS_DIGIT);
        illegal_hit = cap_q && (dec.kind == SEL_IS_ILLEGAL);
        order_err   = digit_hit && (state == LOCKED) && (dec.idx != exp);
        frame_end   = digit_hit && (state == LOCKED) && (dec.idx == exp) && (exp == 2'd3);
        expire      = !digit_hit && (idle_cnt == TIMEOUT_M1);
    end

    always_ff @(posedge CP50 or negedge nCR) begin
        if (!nCR) begin
            state      <= HUNT;
            exp        <= 2'd0;
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            frame_done <= frame_end;
            seq_err    <= illegal_hit || order_err;
            if (illegal_hit) begin
                state <= HUNT;
            end else if (digit_hit) begin
                if (state == HUNT) begin
                    if (dec.idx == 2'd0) begin
                        state <= LOCKED;
                        exp   <= 2'd1;
                    end
                end else if (dec.idx == exp) begin
                    exp <= exp + 2'd1;
                end else begin
                    state <= HUNT;
                end
            end else if (expire) begin
                state <= HUNT;
            end
            if ((illegal_hit || order_err) && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // A digit capture always beats a coincident timeout; HEX registers survive a timeout.
    always_ff @(posedge CP50 or negedge nCR) begin
        if (!nCR) begin
            for (int i = 0; i < 4; i++) begin
                hex_q[i] <= SEG_BLANK;
            end
            valid    <= 4'b0000;
            idle_cnt <= 16'd0;
            timeout  <= 1'b0;
        end else if (digit_hit) begin
            hex_q[dec.idx] <= cap_hex;
            valid[dec.idx] <= 1'b1;
            idle_cnt       <= 16'd0;
            timeout        <= 1'b0;
        end else begin
            if (idle_cnt != 16'hFFFF) begin
                idle_cnt <= idle_cnt + 16'd1;
            end
            if (expire) begin
                valid   <= 4'b0000;
                timeout <= 1'b1;
            end
        end
    end

    assign bus.HEX0      = hex_q[0];
    assign bus.HEX1      = hex_q[1];
    assign bus.HEX2      = hex_q[2];
    assign bus.HEX3      = hex_q[3];
    assign bus.Valid     = valid;
    assign bus.FrameDone = frame_done;
    assign bus.SeqErr    = seq_err;
    assign bus.Timeout   = timeout;
    assign bus.ErrCnt    = err_cnt;

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receiving end of the multiplexed 4-digit seven-segment bus driven by the clock's display scanner. Samples the active-low one-hot digit select and the shared 7-bit segment pattern, filters glitches, and demultiplexes them back into four per-digit segment registers with per-digit valid flags. Also tracks scan order, flags protocol errors, and detects a stalled scanner. Used on the display board and in self-test loopback of the clock design.

## Interface
- STABLE_CYC, 4: consecutive identical synchronised samples required before a digit is captured (legal range 1–15).
- TIMEOUT_CYC, 4096: clock cycles without any capture before the link is declared dead (legal range 16–65535).
- CP50  input  1  system clock, all logic on rising edge.
- nCR  input  1  reset, asynchronous, active-low.
- Choose  input  4  digit select, active-low one-hot (1110 = digit 0 … 0111 = digit 3, 1111 = blank).
- HEX  input  7  segment pattern for the selected digit.
- HEX0, HEX1, HEX2, HEX3  output  7 each  captured segment pattern per digit.
- Valid  output  4  bit n set once HEXn has been captured since reset/timeout.
- FrameDone  output  1  one-cycle pulse after a complete in-order 0→1→2→3 frame.
- SeqErr  output  1  one-cycle pulse on out-of-order capture or illegal select.
- Timeout  output  1  level, high while link is dead.
- ErrCnt  output  8  saturating count of SeqErr pulses.

## Operation
- Choose and HEX pass through a 2-flop synchroniser (s1, s2); s3 holds previous s2.
- Stability counter: if {s2} == {s3}, increment, saturating at STABLE_CYC; else load 1. Capture event fires only on the cycle the counter transitions to STABLE_CYC (one capture per stable dwell, no repeats).
- Select decode on capture: 1110/1101/1011/0111 → index 0–3; write HEXn, set Valid[n]. 1111 → no capture, no error. Any other code → no write, SeqErr.
- Sequence FSM, states HUNT and LOCKED, register exp (2 bits):
  - HUNT: capture of index 0 → LOCKED, exp=1; other indices captured normally, no error.
  - LOCKED: capture of index == exp → exp+1 (mod 4); if the index was 3, FrameDone. Capture of index != exp → SeqErr, HUNT. Illegal select → SeqErr, HUNT.
- Idle counter (16 bits): cleared on every capture, else increments, saturating. Reaching TIMEOUT_CYC → Valid=0000, FSM=HUNT, Timeout=1. Timeout clears on the next capture. HEX0–3 are retained through timeout.
- ErrCnt increments on each SeqErr, holds at 255.
- Simultaneous timeout threshold and capture: capture wins, with counter cleared and Timeout unchanged-low.

## Timing
- Reset values: HEX0–3 = 7'h7F (all segments off), Valid=0000, FrameDone=0, SeqErr=0, Timeout=0, ErrCnt=0, FSM=HUNT, exp=0, counters 0, synchroniser flops = Choose 1111 / HEX 7F.
- Reset mid-dwell or mid-frame aborts everything. The first capture after deassert requires a full STABLE_CYC dwell.
- Latency: an input held from edge k produces registered HEXn/Valid updates at edge k+STABLE_CYC+2. FrameDone and SeqErr are asserted in that same cycle, as registered one-cycle pulses.
- The sender must hold each digit ≥ STABLE_CYC+1 cycles. Shorter dwells are ignored silently.
- FrameDone and SeqErr are never high in the same cycle.

## Structure
- Shared package clock_disp_pkg: select codes SEL_D0..SEL_D3, SEL_BLANK, 7'h7F blank pattern constant, 2-bit digit-index type, FSM state enum.
- One sub-module: sync_ff (parameterised-width two-flop synchroniser with async active-low reset), instantiated once for the 11-bit {Choose,HEX} bus.

## Test plan
- Reset, then scan 1110/7'h40, 1101/7'h79, 1011/7'h24, 0111/7'h30, each held 8 cycles → HEX0..3 = 40,79,24,30. Valid goes 0001→1111. One FrameDone 6 cycles after digit-3 onset.
- Digit 0 held only 3 cycles (STABLE_CYC=4) → no HEX0 update, Valid unchanged, no error.
- While locked, scan 0,1,3 → SeqErr pulse at the digit-3 capture, ErrCnt=1, HEX3 still written, no FrameDone until the next 0,1,2,3.
- Choose=1100 held 8 cycles → SeqErr, ErrCnt+1, no register written. Choose=1111 held 8 cycles → nothing.
- Complete one frame, then hold inputs changing every 2 cycles for 4096+ cycles → Timeout=1, Valid=0000, HEX0–3 retained. Next valid capture → Timeout=0.
- Assert nCR low mid-frame for 1 cycle → all outputs return to reset values immediately (asynchronously), ErrCnt=0.
